// File: rtl/acam_fifo_readout_sched.sv
// acam_fifo_readout_sched
// Sequences pops of the two ACAM TDC output FIFOs (reg 8 / reg 9) over the
// shared data bus, arbitrating round-robin. Each raw 28-bit word is handed
// downstream through a valid/ready handshake. Single 125 MHz clock domain.
module acam_fifo_readout_sched #(
  parameter int unsigned g_setup_cycles    = 1,
  parameter int unsigned g_rd_low_cycles   = 4,
  parameter int unsigned g_recovery_cycles = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        acq_en_i,
  input  logic        ef1_i,
  input  logic        ef2_i,
  input  logic [27:0] data_bus_i,
  output logic [3:0]  adr_o,
  output logic        cs_n_o,
  output logic        rd_n_o,
  output logic [27:0] tstamp_o,
  output logic        tstamp_fifo_o,
  output logic        tstamp_valid_o,
  input  logic        tstamp_ready_i,
  output logic        busy_o,
  output logic [31:0] rd_cnt_o
);

  localparam int unsigned DATA_W  = 28;
  localparam int unsigned ADR_W   = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned RDCNT_W = 32;
  localparam int unsigned SYNC_W  = 2;

  localparam logic [ADR_W-1:0] ADR_FIFO1 = ADR_W'(8);
  localparam logic [ADR_W-1:0] ADR_FIFO2 = ADR_W'(9);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(g_setup_cycles - 1);
  localparam logic [CNT_W-1:0] RD_LOW_LAST  = CNT_W'(g_rd_low_cycles - 1);
  localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(g_recovery_cycles - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RD_LOW,
    ST_OUTPUT,
    ST_RECOVER
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sel_q, sel_d;
  logic                 ptr_q, ptr_d;
  logic [SYNC_W-1:0]    ef1_sync, ef2_sync;
  logic                 ef1_s, ef2_s;

  logic [ADR_W-1:0]     adr_d;
  logic                 cs_n_d;
  logic                 rd_n_d;
  logic [DATA_W-1:0]    tstamp_d;
  logic                 tstamp_fifo_d;
  logic                 tstamp_valid_d;
  logic                 busy_d;
  logic [RDCNT_W-1:0]   rd_cnt_d;
  logic                 pick;

  // Two-flop synchronisers for the asynchronous ACAM empty flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ef1_sync <= '1;
      ef2_sync <= '1;
    end else begin
      ef1_sync <= {ef1_sync[0], ef1_i};
      ef2_sync <= {ef2_sync[0], ef2_i};
    end
  end

  assign ef1_s = ef1_sync[SYNC_W-1];
  assign ef2_s = ef2_sync[SYNC_W-1];

  // State register and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      sel_q          <= 1'b0;
      ptr_q          <= 1'b0;
      adr_o          <= '0;
      cs_n_o         <= 1'b1;
      rd_n_o         <= 1'b1;
      tstamp_o       <= '0;
      tstamp_fifo_o  <= 1'b0;
      tstamp_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      rd_cnt_o       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sel_q          <= sel_d;
      ptr_q          <= ptr_d;
      adr_o          <= adr_d;
      cs_n_o         <= cs_n_d;
      rd_n_o         <= rd_n_d;
      tstamp_o       <= tstamp_d;
      tstamp_fifo_o  <= tstamp_fifo_d;
      tstamp_valid_o <= tstamp_valid_d;
      busy_o         <= busy_d;
      rd_cnt_o       <= rd_cnt_d;
    end
  end

  // FIFO choice: the only non-empty one, otherwise the round-robin pointer
  always_comb begin
    pick = ptr_q;
    if (ef1_s) begin
      pick = 1'b1;
    end else if (ef2_s) begin
      pick = 1'b0;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sel_d          = sel_q;
    ptr_d          = ptr_q;
    adr_d          = adr_o;
    cs_n_d         = cs_n_o;
    rd_n_d         = rd_n_o;
    tstamp_d       = tstamp_o;
    tstamp_fifo_d  = tstamp_fifo_o;
    tstamp_valid_d = tstamp_valid_o;
    rd_cnt_d       = rd_cnt_o;

    unique case (state_q)
      ST_IDLE: begin
        if (acq_en_i && (!ef1_s || !ef2_s)) begin
          sel_d   = pick;
          adr_d   = pick ? ADR_FIFO2 : ADR_FIFO1;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          rd_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_RD_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RD_LOW: begin
        if (cnt_q == RD_LOW_LAST) begin
          tstamp_d       = data_bus_i;
          tstamp_fifo_d  = sel_q;
          rd_n_d         = 1'b1;
          cs_n_d         = 1'b1;
          tstamp_valid_d = 1'b1;
          rd_cnt_d       = rd_cnt_o + RDCNT_W'(1);
          ptr_d          = ~sel_q;
          cnt_d          = '0;
          state_d        = ST_OUTPUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_OUTPUT: begin
        if (tstamp_ready_i) begin
          tstamp_valid_d = 1'b0;
          cnt_d          = '0;
          state_d        = ST_RECOVER;
        end
      end

      ST_RECOVER: begin
        if (cnt_q == RECOVER_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_acam_fifo_readout_sched.sv
// Bench for acam_fifo_readout_sched: scenario tasks plus a scoreboard that
// checks every accepted timestamp word against the expected queue.
module tb_acam_fifo_readout_sched;

  logic        clk;
  logic        rst_i;
  logic        acq_en_i;
  logic        ef1_i;
  logic        ef2_i;
  logic [27:0] data_bus_i = '0;
  logic [3:0]  adr_o;
  logic        cs_n_o;
  logic        rd_n_o;
  logic [27:0] tstamp_o;
  logic        tstamp_fifo_o;
  logic        tstamp_valid_o;
  logic        tstamp_ready_i;
  logic        busy_o;
  logic [31:0] rd_cnt_o;

  int checks = 0;
  int passed = 0;

  logic [28:0] exp_q[$];
  logic [27:0] bus_q[$];
  logic        prev_rd_n_bus = 1'b1;

  acam_fifo_readout_sched dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .acq_en_i       (acq_en_i),
    .ef1_i          (ef1_i),
    .ef2_i          (ef2_i),
    .data_bus_i     (data_bus_i),
    .adr_o          (adr_o),
    .cs_n_o         (cs_n_o),
    .rd_n_o         (rd_n_o),
    .tstamp_o       (tstamp_o),
    .tstamp_fifo_o  (tstamp_fifo_o),
    .tstamp_valid_o (tstamp_valid_o),
    .tstamp_ready_i (tstamp_ready_i),
    .busy_o         (busy_o),
    .rd_cnt_o       (rd_cnt_o)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // ACAM bus model: each rd_n falling edge pops the next FIFO word onto the bus
  always @(negedge clk) begin
    if (prev_rd_n_bus && !rd_n_o) begin
      data_bus_i = (bus_q.size() > 0) ? bus_q.pop_front() : 28'h0;
    end
    prev_rd_n_bus = rd_n_o;
  end

  // Scoreboard: a word is consumed on each cycle with valid and ready high
  always @(negedge clk) begin
    logic [28:0] exp_w;
    #1;
    if (!rst_i && tstamp_valid_o && tstamp_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_unexpected: got fifo=%0d data=%h, nothing expected",
                 tstamp_fifo_o, tstamp_o);
      end else begin
        exp_w = exp_q.pop_front();
        if ({tstamp_fifo_o, tstamp_o} !== exp_w)
          $display("FAIL scoreboard_word: got fifo=%0d data=%h expected fifo=%0d data=%h",
                   tstamp_fifo_o, tstamp_o, exp_w[28], exp_w[27:0]);
        else
          passed++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy_o && !tstamp_valid_o) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_rd_low(output bit to);
    to = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!rd_n_o) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  // Waits for chip select and then marks FIFO1 empty so exactly one pop happens
  task automatic wait_cs_then_empty(output bit to);
    to = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!cs_n_o) begin
        ef1_i = 1'b1;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; acq_en_i = 1'b0; ef1_i = 1'b1; ef2_i = 1'b1; tstamp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_n_o, cs_n_o, tstamp_valid_o, busy_o, tstamp_fifo_o} !== 5'b11000)
      $display("FAIL reset_ctrl: got %b expected 11000",
               {rd_n_o, cs_n_o, tstamp_valid_o, busy_o, tstamp_fifo_o});
    else passed++;
    checks++;
    if (adr_o !== 4'd0) $display("FAIL reset_adr: got %h expected 0", adr_o);
    else passed++;
    checks++;
    if (tstamp_o !== 28'h0) $display("FAIL reset_tstamp: got %h expected 0", tstamp_o);
    else passed++;
    checks++;
    if (rd_cnt_o !== 32'h0) $display("FAIL reset_rd_cnt: got %h expected 0", rd_cnt_o);
    else passed++;
    rst_i = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || cs_n_o !== 1'b1)
      $display("FAIL idle_when_empty: got busy=%b cs_n=%b expected busy=0 cs_n=1", busy_o, cs_n_o);
    else passed++;
  endtask

  task automatic test_single_read();
    int cs_fall, rd_fall, rd_rise, n_cs;
    logic pcs, prd;
    logic [3:0] adr_at;
    logic [27:0] val_at;
    bit got_valid;
    cs_fall = -100; rd_fall = -100; rd_rise = -100; n_cs = 0;
    adr_at = 4'hx; val_at = 28'hx; got_valid = 1'b0;
    bus_q.push_back(28'hABCDEF1);
    exp_q.push_back({1'b0, 28'hABCDEF1});
    tstamp_ready_i = 1'b1; acq_en_i = 1'b1; ef1_i = 1'b0; ef2_i = 1'b1;
    pcs = cs_n_o; prd = rd_n_o;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (pcs && !cs_n_o) begin cs_fall = t; n_cs++; ef1_i = 1'b1; end
      if (prd && !rd_n_o) begin rd_fall = t; adr_at = adr_o; end
      if (!prd && rd_n_o) rd_rise = t;
      if (tstamp_valid_o && !got_valid) begin got_valid = 1'b1; val_at = tstamp_o; end
      pcs = cs_n_o; prd = rd_n_o;
    end
    checks++;
    if (n_cs !== 1) $display("FAIL single_read_count: got %0d reads expected 1", n_cs);
    else passed++;
    checks++;
    if (rd_fall - cs_fall !== 1)
      $display("FAIL single_setup: got %0d cycles cs_n before rd_n expected 1", rd_fall - cs_fall);
    else passed++;
    checks++;
    if (rd_rise - rd_fall !== 4)
      $display("FAIL single_rd_low: got %0d cycles expected 4", rd_rise - rd_fall);
    else passed++;
    checks++;
    if (adr_at !== 4'd8) $display("FAIL single_adr: got %h expected 8", adr_at);
    else passed++;
    checks++;
    if (val_at !== 28'hABCDEF1) $display("FAIL single_tstamp: got %h expected abcdef1", val_at);
    else passed++;
    checks++;
    if (rd_cnt_o !== 32'd1) $display("FAIL single_rd_cnt: got %0d expected 1", rd_cnt_o);
    else passed++;
  endtask

  task automatic test_round_robin();
    int fall_t[4];
    logic [3:0] adr_at[4];
    int n_rd, n_cs;
    logic pcs, prd;
    bit quiet;
    acq_en_i = 1'b0; ef1_i = 1'b1; ef2_i = 1'b1;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      bus_q.push_back(28'h0100000 + 28'(i));
      exp_q.push_back({1'(i % 2), 28'h0100000 + 28'(i)});
    end
    n_rd = 0; n_cs = 0;
    tstamp_ready_i = 1'b1; acq_en_i = 1'b1; ef1_i = 1'b0; ef2_i = 1'b0;
    pcs = cs_n_o; prd = rd_n_o;
    for (int t = 0; t < 150; t++) begin
      @(negedge clk);
      if (pcs && !cs_n_o) begin
        n_cs++;
        if (n_cs == 4) begin ef1_i = 1'b1; ef2_i = 1'b1; end
      end
      if (prd && !rd_n_o) begin
        if (n_rd < 4) begin fall_t[n_rd] = t; adr_at[n_rd] = adr_o; end
        n_rd++;
      end
      pcs = cs_n_o; prd = rd_n_o;
      if (n_rd >= 4 && !busy_o) break;
    end
    checks++;
    if (n_rd !== 4) $display("FAIL rr_count: got %0d reads expected 4", n_rd);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (adr_at[i] !== 4'(8 + (i % 2)))
        $display("FAIL rr_adr_%0d: got %h expected %h", i, adr_at[i], 4'(8 + (i % 2)));
      else passed++;
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (fall_t[i] - fall_t[i-1] !== 11)
        $display("FAIL rr_period_%0d: got %0d cycles expected 11", i, fall_t[i] - fall_t[i-1]);
      else passed++;
    end
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!rd_n_o || !cs_n_o) quiet = 1'b0;
    end
    checks++;
    if (!quiet || rd_cnt_o !== 32'd4)
      $display("FAIL rr_stop: got quiet=%b rd_cnt=%0d expected quiet=1 rd_cnt=4", quiet, rd_cnt_o);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit to, stable, quiet;
    logic [27:0] hold;
    int k_cs, k_rd;
    bus_q.push_back(28'h0BEEF01);
    bus_q.push_back(28'h0BEEF02);
    exp_q.push_back({1'b0, 28'h0BEEF01});
    exp_q.push_back({1'b0, 28'h0BEEF02});
    tstamp_ready_i = 1'b0; acq_en_i = 1'b1; ef1_i = 1'b0; ef2_i = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tstamp_valid_o) begin to = 1'b0; break; end
    end
    checks++;
    if (to) $display("FAIL bp_valid_timeout: got no valid expected valid within 60 cycles");
    else passed++;
    hold = tstamp_o; stable = 1'b1; quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!tstamp_valid_o || tstamp_o !== hold) stable = 1'b0;
      if (!rd_n_o || !cs_n_o) quiet = 1'b0;
    end
    checks++;
    if (!stable || hold !== 28'h0BEEF01)
      $display("FAIL bp_hold: got stable=%b data=%h expected stable=1 data=beef01", stable, hold);
    else passed++;
    checks++;
    if (!quiet) $display("FAIL bp_bus_quiet: got bus activity expected none while stalled");
    else passed++;
    tstamp_ready_i = 1'b1;
    k_cs = -1; k_rd = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!cs_n_o && k_cs < 0) begin k_cs = k; ef1_i = 1'b1; end
      if (!rd_n_o && k_rd < 0) k_rd = k;
    end
    checks++;
    if (k_cs !== 6 || k_rd !== 7)
      $display("FAIL bp_recover: got cs_n at %0d rd_n at %0d expected 6 and 7", k_cs, k_rd);
    else passed++;
    wait_idle(to);
    checks++;
    if (to) $display("FAIL bp_idle_timeout: got busy expected idle");
    else passed++;
  endtask

  task automatic test_acq_drop();
    bit to;
    int n_cs;
    logic pcs;
    logic [31:0] base;
    base = rd_cnt_o;
    bus_q.push_back(28'h0C0FFEE);
    exp_q.push_back({1'b0, 28'h0C0FFEE});
    tstamp_ready_i = 1'b1; ef1_i = 1'b0; ef2_i = 1'b1; acq_en_i = 1'b1;
    wait_rd_low(to);
    acq_en_i = 1'b0;
    checks++;
    if (to) $display("FAIL drop_rd_timeout: got no rd_n low expected a read");
    else passed++;
    n_cs = 0; pcs = cs_n_o;
    repeat (40) begin
      @(negedge clk);
      if (pcs && !cs_n_o) n_cs++;
      pcs = cs_n_o;
    end
    checks++;
    if (rd_cnt_o !== base + 32'd1 || n_cs !== 0 || busy_o !== 1'b0)
      $display("FAIL acq_drop: got rd_cnt=%0d new_reads=%0d busy=%b expected rd_cnt=%0d new_reads=0 busy=0",
               rd_cnt_o, n_cs, busy_o, base + 32'd1);
    else passed++;
    ef1_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit to;
    bus_q.push_back(28'h0DEAD00);
    bus_q.push_back(28'h0FACE01);
    exp_q.push_back({1'b0, 28'h0FACE01});
    tstamp_ready_i = 1'b1; ef1_i = 1'b0; ef2_i = 1'b1; acq_en_i = 1'b1;
    wait_rd_low(to);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (to || {rd_n_o, cs_n_o, tstamp_valid_o, busy_o} !== 4'b1100 || rd_cnt_o !== 32'd0)
      $display("FAIL reset_mid: got rd_n/cs_n/valid/busy=%b rd_cnt=%0d expected 1100 rd_cnt=0",
               {rd_n_o, cs_n_o, tstamp_valid_o, busy_o}, rd_cnt_o);
    else passed++;
    rst_i = 1'b0;
    wait_cs_then_empty(to);
    @(negedge clk);
    checks++;
    if (to || rd_n_o !== 1'b0 || adr_o !== 4'd8)
      $display("FAIL reset_restart: got rd_n=%b adr=%h expected rd_n=0 adr=8", rd_n_o, adr_o);
    else passed++;
    wait_idle(to);
    checks++;
    if (to || rd_cnt_o !== 32'd1)
      $display("FAIL reset_restart_cnt: got rd_cnt=%0d expected 1", rd_cnt_o);
    else passed++;
  endtask

  task automatic test_rd_cnt_wrap();
    bit to;
    force dut.rd_cnt_o = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.rd_cnt_o;
    @(negedge clk);
    bus_q.push_back(28'h0123456);
    exp_q.push_back({1'b0, 28'h0123456});
    tstamp_ready_i = 1'b1; ef1_i = 1'b0; ef2_i = 1'b1; acq_en_i = 1'b1;
    wait_cs_then_empty(to);
    wait_idle(to);
    checks++;
    if (to || rd_cnt_o !== 32'h0)
      $display("FAIL rd_cnt_wrap: got %h expected 00000000", rd_cnt_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_acq_drop();
    test_reset_mid();
    test_rd_cnt_wrap();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d words outstanding expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
